// File: rtl/attr_int_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// attr_int_accumulator_pkg : shared widths, ASCII bounds and FSM encoding
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package attr_int_accumulator_pkg;

    localparam int CHAR_BITES          = 8;
    localparam int ATTRIBUTE_VAL_BITES = 16;

    localparam logic [CHAR_BITES-1:0] ASCII_ZERO = 8'd48;
    localparam logic [CHAR_BITES-1:0] ASCII_NINE = 8'd57;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } acc_state_t;

    function automatic logic is_digit(input logic [CHAR_BITES-1:0] ch);
        return (ch >= ASCII_ZERO) && (ch <= ASCII_NINE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/attr_int_accumulator_char_to_int.sv
// ---------------------------------------------------------------------------
// attr_int_accumulator_char_to_int : ASCII digit to value, 0 for non-digits
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module attr_int_accumulator_char_to_int
    import attr_int_accumulator_pkg::*;
(
    input  logic [CHAR_BITES-1:0] char_in,
    output logic [3:0]            int_val
);

    logic [CHAR_BITES-1:0] w_offset;

    assign w_offset = char_in - ASCII_ZERO;
    assign int_val  = is_digit(char_in) ? w_offset[3:0] : 4'd0;

endmodule

`default_nettype wire

// File: rtl/attr_int_accumulator.sv
// ---------------------------------------------------------------------------
// attr_int_accumulator : streaming decimal parser with saturating accumulator
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module attr_int_accumulator
    import attr_int_accumulator_pkg::*;
#(
    parameter int VAL_W = ATTRIBUTE_VAL_BITES
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [CHAR_BITES-1:0] char_in,
    input  logic                  char_valid,
    input  logic                  char_last,
    output logic                  char_ready,
    output logic [VAL_W-1:0]      val_out,
    output logic [CHAR_BITES-1:0] term_char,
    output logic                  overflow,
    output logic                  val_valid,
    input  logic                  val_ready
);

    localparam logic [VAL_W+3:0] C_MAX = {4'b0000, {VAL_W{1'b1}}};
    localparam logic [VAL_W+3:0] C_TEN = (VAL_W+4)'(10);

    acc_state_t        r_state;
    logic [VAL_W-1:0]  r_acc;
    logic              r_ovf;

    logic [3:0]        w_digit;
    logic              w_is_digit;
    logic              w_accept;
    logic [VAL_W+3:0]  w_sum;
    logic              w_sat;
    logic [VAL_W-1:0]  w_acc_next;
    logic              w_ovf_next;

    attr_int_accumulator_char_to_int u_char_to_int (
        .char_in (char_in),
        .int_val (w_digit)
    );

    // The converter maps non-digits to 0, so digit detection is separate.
    assign w_is_digit = is_digit(char_in);

    // Gated by resetn so the block never advertises ready while held in reset.
    assign char_ready = resetn && (r_state != EMIT);
    assign w_accept   = char_valid && char_ready;

    // Widened by 4 bits so acc*10+9 cannot wrap before the saturation compare.
    assign w_sum      = ({4'b0000, r_acc} * C_TEN) + {{VAL_W{1'b0}}, w_digit};
    assign w_sat      = (w_sum > C_MAX);
    assign w_acc_next = w_sat ? {VAL_W{1'b1}} : w_sum[VAL_W-1:0];
    assign w_ovf_next = r_ovf || w_sat;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            val_out   <= '0;
            term_char <= '0;
            overflow  <= 1'b0;
            val_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && w_is_digit) begin
                        r_acc <= VAL_W'(w_digit);
                        r_ovf <= 1'b0;
                        if (char_last) begin
                            val_out   <= VAL_W'(w_digit);
                            term_char <= '0;
                            overflow  <= 1'b0;
                            val_valid <= 1'b1;
                            r_state   <= EMIT;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        if (w_is_digit) begin
                            r_acc <= w_acc_next;
                            r_ovf <= w_ovf_next;
                            if (char_last) begin
                                val_out   <= w_acc_next;
                                term_char <= '0;
                                overflow  <= w_ovf_next;
                                val_valid <= 1'b1;
                                r_state   <= EMIT;
                            end
                        end else begin
                            val_out   <= r_acc;
                            term_char <= char_in;
                            overflow  <= r_ovf;
                            val_valid <= 1'b1;
                            r_state   <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (val_ready) begin
                        val_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    val_valid <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_attr_int_accumulator.sv
// ---------------------------------------------------------------------------
// tb_attr_int_accumulator : per-cycle vector table for attr_int_accumulator
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_attr_int_accumulator;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_last;
    logic        char_ready;
    logic [15:0] val_out;
    logic [7:0]  term_char;
    logic        overflow;
    logic        val_valid;
    logic        val_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  ch;
        logic        vld;
        logic        last;
        logic        vr;
        logic        rst;
        logic        e_rdy;
        logic        e_vv;
        logic        chk;
        logic [15:0] e_val;
        logic [7:0]  e_term;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    attr_int_accumulator #(.VAL_W(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_last  (char_last),
        .char_ready (char_ready),
        .val_out    (val_out),
        .term_char  (term_char),
        .overflow   (overflow),
        .val_valid  (val_valid),
        .val_ready  (val_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [7:0] ch, input logic vld, input logic last,
                                input logic vr, input logic rst, input logic e_rdy,
                                input logic e_vv, input logic chk, input logic [15:0] e_val,
                                input logic [7:0] e_term, input logic e_ovf);
        vec_t v;
        v.ch = ch; v.vld = vld; v.last = last; v.vr = vr; v.rst = rst;
        v.e_rdy = e_rdy; v.e_vv = e_vv; v.chk = chk;
        v.e_val = e_val; v.e_term = e_term; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endfunction

    // Plain accepted character: ready, no result pending.
    function automatic void chr(input logic [7:0] ch, input logic last);
        add(ch, 1'b1, last, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
    endfunction

    // EMIT cycle with expected result.
    function automatic void emit(input logic [15:0] v, input logic [7:0] t, input logic o);
        add(8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, v, t, o);
    endfunction

    function automatic void str(input string s);
        for (int i = 0; i < s.len(); i++) chr(s[i], 1'b0);
    endfunction

    initial begin
        resetn     = 1'b0;
        char_in    = 8'd0;
        char_valid = 1'b0;
        char_last  = 1'b0;
        val_ready  = 1'b0;

        str("123;");
        emit(16'd123, 8'h3B, 1'b0);
        str("  4x");
        emit(16'd4, 8'h78, 1'b0);
        str("70000 ");
        emit(16'd65535, 8'h20, 1'b1);
        str("65535 ");
        emit(16'd65535, 8'h20, 1'b0);
        str("9;");
        for (int i = 0; i < 3; i++)
            add("7", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd9, 8'h3B, 1'b0);
        add("7", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd9, 8'h3B, 1'b0);
        chr("7", 1'b0);
        chr(";", 1'b0);
        emit(16'd7, 8'h3B, 1'b0);
        chr("4", 1'b0);
        chr("2", 1'b1);
        emit(16'd42, 8'h00, 1'b0);
        chr(";", 1'b1);
        add(8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
        chr("8", 1'b1);
        emit(16'd8, 8'h00, 1'b0);
        str("999999;");
        emit(16'd65535, 8'h3B, 1'b1);
        str("12");
        add(8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);
        add("5", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
        chr(";", 1'b0);
        emit(16'd5, 8'h3B, 1'b0);
        add(8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0);

        // Reset state while resetn is held low.
        repeat (2) @(negedge clk);
        #1;
        check("reset char_ready", 32'(char_ready), 32'd0);
        check("reset val_valid",  32'(val_valid),  32'd0);
        check("reset val_out",    32'(val_out),    32'd0);
        check("reset term_char",  32'(term_char),  32'd0);
        check("reset overflow",   32'(overflow),   32'd0);

        foreach (vecs[r]) begin
            @(negedge clk);
            resetn     = ~vecs[r].rst;
            char_in    = vecs[r].ch;
            char_valid = vecs[r].vld;
            char_last  = vecs[r].last;
            val_ready  = vecs[r].vr;
            #1;
            check($sformatf("row%0d char_ready", r), 32'(char_ready), 32'(vecs[r].e_rdy));
            check($sformatf("row%0d val_valid", r),  32'(val_valid),  32'(vecs[r].e_vv));
            if (vecs[r].chk) begin
                check($sformatf("row%0d val_out", r),   32'(val_out),   32'(vecs[r].e_val));
                check($sformatf("row%0d term_char", r), 32'(term_char), 32'(vecs[r].e_term));
                check($sformatf("row%0d overflow", r),  32'(overflow),  32'(vecs[r].e_ovf));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
